// File: rtl/prbs_checker.sv
// Receive-side checker for the 13-bit Fibonacci PRBS (s[n] = s[n-13] ^ s[n-6]).
// Fills history from the line, verifies a run of good predictions, then free-runs and counts errors.
module prbs_checker #(
   parameter int WIDTH      = 13,
   parameter int TAP        = 5,
   parameter int LOCK_COUNT = 16,
   parameter int WINDOW     = 32,
   parameter int ERR_LIMIT  = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);
   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int WERR_W = $clog2(ERR_LIMIT + 1);

   typedef enum logic [1:0] {S_FILL, S_VERIFY, S_LOCKED} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WERR_W-1:0] werr_q, werr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;

   logic pred, miss, hist_zero, run_hit, err_trip;

   assign pred      = hist_q[WIDTH-1] ^ hist_q[TAP];
   assign miss      = in_bit ^ pred;
   // An all-zero history predicts zeros forever, so it never earns lock.
   assign hist_zero = (hist_q == '0);
   assign run_hit   = !miss && !hist_zero && (run_q == RUN_W'(LOCK_COUNT - 1));
   assign err_trip  = miss && (werr_q == WERR_W'(ERR_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FILL;
         hist_q   <= '0;
         fill_q   <= '0;
         run_q    <= '0;
         win_q    <= '0;
         werr_q   <= '0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hist_q   <= hist_d;
         fill_q   <= fill_d;
         run_q    <= run_d;
         win_q    <= win_d;
         werr_q   <= werr_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_valid) begin
         case (state_q)
            S_FILL:   if (fill_q == FILL_W'(WIDTH - 1)) state_d = S_VERIFY;
            S_VERIFY: if (run_hit) state_d = S_LOCKED;
            S_LOCKED: if (err_trip) state_d = S_FILL;
            default:  state_d = S_FILL;
         endcase
      end
   end

   always_comb begin
      hist_d   = hist_q;
      fill_d   = fill_q;
      run_d    = run_q;
      win_d    = win_q;
      werr_d   = werr_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      locked_d = (state_d == S_LOCKED);
      if (in_valid) begin
         case (state_q)
            S_FILL: begin
               hist_d = {hist_q[WIDTH-2:0], in_bit};
               fill_d = (state_d == S_VERIFY) ? '0 : fill_q + 1'b1;
               run_d  = '0;
            end
            S_VERIFY: begin
               hist_d = {hist_q[WIDTH-2:0], in_bit};
               run_d  = (!miss && !hist_zero && !run_hit) ? run_q + 1'b1 : '0;
               if (run_hit) begin
                  win_d  = '0;
                  werr_d = '0;
               end
            end
            S_LOCKED: begin
               // Free-run on our own prediction so a flipped bit cannot poison later predictions.
               hist_d = {hist_q[WIDTH-2:0], pred};
               win_d  = win_q + 1'b1;
               if (miss) begin
                  err_d  = 1'b1;
                  werr_d = werr_q + 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               end
               if (err_trip) begin
                  fill_d = '0;
                  run_d  = '0;
                  win_d  = '0;
                  werr_d = '0;
               end else if (win_q == WIN_W'(WINDOW - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: default instance plus a small-window, 2-bit-counter instance,
// both driven with the same stream and checked against a recurrence-based reference model.
module tb_prbs_checker;
   logic        clk = 1'b0;
   logic        rst, in_bit, in_valid;
   logic        locked0, err0, locked1, err1;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   prbs_checker dut0 (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
      .locked(locked0), .err(err0), .err_count(cnt0)
   );

   prbs_checker #(.CNT_W(2), .WINDOW(4), .ERR_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
      .locked(locked1), .err(err1), .err_count(cnt1)
   );

   // Reference model: mode per instance plus a circular record of the stream it believes in.
   int  m_st[2];
   int  m_fill[2], m_run[2], m_win[2], m_werr[2], m_cnt[2], m_n[2];
   bit  m_err[2];
   bit  m_seen[2][64];
   logic [12:0] gen_r;
   int  vcount;

   function automatic int win_of(int k);
      return (k == 0) ? 32 : 4;
   endfunction

   function automatic int max_of(int k);
      return (k == 0) ? 65535 : 3;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_fill[k] = 0; m_run[k] = 0; m_win[k] = 0;
         m_werr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0; m_n[k] = 64;
         for (int j = 0; j < 64; j++) m_seen[k][j] = 1'b0;
      end
   endfunction

   function automatic void model_step(int k, bit b);
      bit p, z;
      p = m_seen[k][(m_n[k] - 13) % 64] ^ m_seen[k][(m_n[k] - 6) % 64];
      z = 1'b1;
      for (int j = 1; j <= 13; j++) if (m_seen[k][(m_n[k] - j) % 64]) z = 1'b0;
      m_err[k] = 1'b0;
      case (m_st[k])
         0: begin
            m_seen[k][m_n[k] % 64] = b; m_n[k]++;
            m_fill[k]++;
            if (m_fill[k] == 13) begin m_st[k] = 1; m_fill[k] = 0; m_run[k] = 0; end
         end
         1: begin
            m_seen[k][m_n[k] % 64] = b; m_n[k]++;
            if (b == p && !z) m_run[k]++; else m_run[k] = 0;
            if (m_run[k] == 16) begin m_st[k] = 2; m_run[k] = 0; m_win[k] = 0; m_werr[k] = 0; end
         end
         default: begin
            m_seen[k][m_n[k] % 64] = p; m_n[k]++;
            m_win[k]++;
            if (b != p) begin
               m_err[k] = 1'b1;
               m_werr[k]++;
               if (m_cnt[k] < max_of(k)) m_cnt[k]++;
            end
            if (m_werr[k] == 4) begin
               m_st[k] = 0; m_fill[k] = 0; m_run[k] = 0; m_win[k] = 0; m_werr[k] = 0;
            end else if (m_win[k] == win_of(k)) begin
               m_win[k] = 0; m_werr[k] = 0;
            end
         end
      endcase
   endfunction

   function automatic logic [17:0] exp0();
      return {m_st[0] == 2, m_err[0], 16'(m_cnt[0])};
   endfunction

   function automatic logic [3:0] exp1();
      return {m_st[1] == 2, m_err[1], 2'(m_cnt[1])};
   endfunction

   function automatic bit gen_bit();
      gen_r = {gen_r[11:0], gen_r[12] ^ gen_r[5]};
      return gen_r[0];
   endfunction

   task automatic cycle(input bit b, input bit v, input bit r);
      in_bit = b; in_valid = v; rst = r;
      @(posedge clk);
      if (r) begin
         model_reset();
         vcount = 0;
      end else if (v) begin
         model_step(0, b);
         model_step(1, b);
         vcount++;
      end else begin
         m_err[0] = 1'b0;
         m_err[1] = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({locked0, err0, cnt0} !== 18'd0) begin
         n_bad++; $display("FAIL reset dut0: got %h want 0", {locked0, err0, cnt0});
      end
      n_cmp++;
      if ({locked1, err1, cnt1} !== 4'd0) begin
         n_bad++; $display("FAIL reset dut1: got %h want 0", {locked1, err1, cnt1});
      end
   endtask

   task automatic test_lock_latency();
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'h0FFF;
      for (int i = 1; i <= 1029; i++) begin
         cycle(gen_bit(), 1'b1, 1'b0);
         n_cmp++;
         if ({locked0, err0, cnt0} !== {i >= 29, 1'b0, 16'd0}) begin
            n_bad++; $display("FAIL lock_latency dut0 bit %0d: got %h want %h", i, {locked0, err0, cnt0}, {i >= 29, 1'b0, 16'd0});
         end
         n_cmp++;
         if ({locked1, err1, cnt1} !== {i >= 29, 1'b0, 2'd0}) begin
            n_bad++; $display("FAIL lock_latency dut1 bit %0d: got %h want %h", i, {locked1, err1, cnt1}, {i >= 29, 1'b0, 2'd0});
         end
      end
   endtask

   task automatic test_single_error();
      bit b;
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int i = 1; i <= 80; i++) begin
         b = gen_bit();
         if (i == 40) b = ~b;
         cycle(b, 1'b1, 1'b0);
         n_cmp++;
         if (err0 !== (i == 40)) begin
            n_bad++; $display("FAIL single_err pulse bit %0d: got %b want %b", i, err0, i == 40);
         end
         n_cmp++;
         if ({locked1, err1, cnt1} !== exp1()) begin
            n_bad++; $display("FAIL single_err dut1 bit %0d: got %h want %h", i, {locked1, err1, cnt1}, exp1());
         end
      end
      n_cmp++;
      if ({locked0, cnt0} !== {1'b1, 16'd1}) begin
         n_bad++; $display("FAIL single_err final: got l=%b n=%0d want l=1 n=1", locked0, cnt0);
      end
   endtask

   task automatic test_burst_loss();
      bit b;
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int i = 1; i <= 110; i++) begin
         b = gen_bit();
         if (i inside {35, 37, 39, 41, 101, 102, 103, 104}) b = ~b;
         cycle(b, 1'b1, 1'b0);
         n_cmp++;
         if ({locked0, err0, cnt0} !== exp0()) begin
            n_bad++; $display("FAIL burst dut0 bit %0d: got %h want %h", i, {locked0, err0, cnt0}, exp0());
         end
         n_cmp++;
         if ({locked1, err1, cnt1} !== exp1()) begin
            n_bad++; $display("FAIL burst dut1 bit %0d: got %h want %h", i, {locked1, err1, cnt1}, exp1());
         end
         if (i == 40 || i == 41 || i == 69 || i == 70 || i == 110) begin
            n_cmp++;
            if ({locked0, cnt0} !== {i inside {40, 70, 110}, (i == 110) ? 16'd8 : (i == 40) ? 16'd3 : 16'd4}) begin
               n_bad++; $display("FAIL burst milestone bit %0d: got l=%b n=%0d", i, locked0, cnt0);
            end
         end
      end
   endtask

   task automatic test_all_zero();
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 200; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         n_cmp++;
         if ({locked0, err0, cnt0, locked1, err1, cnt1} !== 22'd0) begin
            n_bad++; $display("FAIL all_zero bit %0d: got l0=%b n0=%0d l1=%b n1=%0d want 0", i, locked0, cnt0, locked1, cnt1);
         end
      end
   endtask

   task automatic test_sparse_valid();
      bit v;
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int c = 0; c < 120; c++) begin
         v = (c % 3 == 2);
         cycle(v ? gen_bit() : 1'($urandom), v, 1'b0);
         n_cmp++;
         if ({locked0, err0, cnt0} !== {vcount >= 29, 1'b0, 16'd0}) begin
            n_bad++; $display("FAIL sparse dut0 cyc %0d valid %0d: got %h want %h", c, vcount, {locked0, err0, cnt0}, {vcount >= 29, 1'b0, 16'd0});
         end
         n_cmp++;
         if ({locked1, err1, cnt1} !== exp1()) begin
            n_bad++; $display("FAIL sparse dut1 cyc %0d: got %h want %h", c, {locked1, err1, cnt1}, exp1());
         end
      end
   endtask

   task automatic test_reset_mid_lock();
      bit b;
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int i = 1; i <= 45; i++) begin
         b = gen_bit();
         if (i inside {35, 37, 39}) b = ~b;
         cycle(b, 1'b1, 1'b0);
      end
      n_cmp++;
      if ({locked0, cnt0} !== {1'b1, 16'd3}) begin
         n_bad++; $display("FAIL midreset pre: got l=%b n=%0d want l=1 n=3", locked0, cnt0);
      end
      cycle(gen_bit(), 1'b1, 1'b1);
      n_cmp++;
      if ({locked0, err0, cnt0, locked1, err1, cnt1} !== 22'd0) begin
         n_bad++; $display("FAIL midreset clear: got l0=%b e0=%b n0=%0d l1=%b n1=%0d want 0", locked0, err0, cnt0, locked1, cnt1);
      end
      for (int i = 1; i <= 35; i++) begin
         cycle(gen_bit(), 1'b1, 1'b0);
         n_cmp++;
         if ({locked0, err0, cnt0} !== {i >= 29, 1'b0, 16'd0}) begin
            n_bad++; $display("FAIL midreset relock bit %0d: got %h want %h", i, {locked0, err0, cnt0}, {i >= 29, 1'b0, 16'd0});
         end
      end
   endtask

   task automatic test_saturate();
      bit b;
      int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int i = 1; i <= 60; i++) begin
         b = gen_bit();
         if (i >= 30 && i <= 50 && (i - 30) % 4 == 0) b = ~b;
         cycle(b, 1'b1, 1'b0);
         if (i >= 30 && i <= 50 && (i - 30) % 4 == 0) begin
            n_cmp++;
            if ({locked1, err1, cnt1} !== {1'b1, 1'b1, 2'(sat_exp[(i - 30) / 4])}) begin
               n_bad++; $display("FAIL saturate bit %0d: got l=%b e=%b n=%0d want l=1 e=1 n=%0d", i, locked1, err1, cnt1, sat_exp[(i - 30) / 4]);
            end
         end else if (i >= 29) begin
            n_cmp++;
            if ({locked1, err1} !== 2'b10) begin
               n_bad++; $display("FAIL saturate hold bit %0d: got l=%b e=%b want l=1 e=0", i, locked1, err1);
            end
         end
         n_cmp++;
         if ({locked0, err0, cnt0} !== exp0()) begin
            n_bad++; $display("FAIL saturate dut0 bit %0d: got %h want %h", i, {locked0, err0, cnt0}, exp0());
         end
      end
   endtask

   task automatic test_random();
      bit v, b, r;
      cycle(1'b0, 1'b0, 1'b1);
      gen_r = 13'($urandom_range(1, 8191));
      for (int c = 0; c < 3000; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 599) == 0);
         b = v ? gen_bit() : 1'($urandom);
         if (v && $urandom_range(0, (c < 1500) ? 39 : 7) == 0) b = ~b;
         cycle(b, v, r);
         n_cmp++;
         if ({locked0, err0, cnt0} !== exp0()) begin
            n_bad++; $display("FAIL random dut0 cyc %0d: got %h want %h", c, {locked0, err0, cnt0}, exp0());
         end
         n_cmp++;
         if ({locked1, err1, cnt1} !== exp1()) begin
            n_bad++; $display("FAIL random dut1 cyc %0d: got %h want %h", c, {locked1, err1, cnt1}, exp1());
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; vcount = 0;
      gen_r = 13'h0FFF;
      model_reset();
      test_reset();
      test_lock_latency();
      test_single_error();
      test_burst_loss();
      test_all_zero();
      test_sparse_valid();
      test_reset_mid_lock();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial receiver/checker for the 13-bit Fibonacci LFSR stream produced by the team's RNG (feedback = r[12]^r[5]; the emitted bit is the new LSB, so s[n] = s[n-13] ^ s[n-6]).
- Sits downstream of any link carrying that stream. Loads its history from the stream, confirms lock over a run of consecutive correct bits, then counts bit errors against a locally free-running copy.
- Drops lock when errors are too dense.

Parameters:
- WIDTH, 13, LFSR length; the oldest history bit is a feedback tap.
- TAP, 5, second feedback tap index into history.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- WINDOW, 32, valid bits per error-density window while locked.
- ERR_LIMIT, 4, errors within one window that force loss of lock.
- CNT_W, 16, width of the saturating total error counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  received stream bit.
- in_valid  input  1  in_bit is sampled only on cycles where this is 1.
- locked  output  1  registered; 1 while in LOCKED.
- err  output  1  registered one-cycle pulse per mismatched bit while LOCKED.
- err_count  output  CNT_W  total LOCKED-state errors since reset; saturates at all-ones.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst), as already decided.
- Reset (rst=1 at an edge): state=FILL; history=0, fill count=0, run count=0, window count=0, window error count=0; locked=0, err=0, err_count=0. rst overrides in_valid in the same cycle. Reset mid-lock behaves identically.
- History h[WIDTH-1:0]: h[0] is the newest bit. Prediction p = h[WIDTH-1] ^ h[TAP].
- Cycles with in_valid=0: no state, history or counter change; err=0.
- FILL: each valid bit shifts in (h <= {h[WIDTH-2:0], in_bit}). After the WIDTH-th valid bit, go to VERIFY with run=0.
- VERIFY: each valid bit is compared with p, then the received bit is shifted in.
  - Match and h != 0: run++.
  - Mismatch, or h == 0 (the all-zero lockup state is never accepted): run=0.
  - When run reaches LOCK_COUNT, go to LOCKED. locked=1 on the edge that sampled that bit, so it is visible the next cycle. Window counters clear on entry.
- LOCKED: the history free-runs on the prediction (shift in p, not in_bit), so one corrupted bit counts exactly one error.
  - Mismatch: err=1 for one cycle (registered, one cycle after the bit is sampled); err_count++ unless already all-ones; window error count++.
  - Every valid bit: window count++.
  - If window error count reaches ERR_LIMIT, including on the WINDOW-th bit itself, go to FILL on that edge. locked=0 the next cycle; fill count, run and window counters clear; err_count holds.
  - Otherwise, when window count reaches WINDOW, both window counters clear. An error on that last bit counts toward the closing window.
- err is 0 in FILL and VERIFY. err_count changes only in LOCKED or on reset.
- Latency: lock is declared at valid bit WIDTH+LOCK_COUNT = 29 with defaults.

Test Plan:
- Clean stream from generator seed 13'h0FFF, in_valid=1 continuously -> locked=0 through valid bit 29, locked=1 in the cycle after bit 29 is sampled; err=0 and err_count=0 over the next 1000 bits.
- Locked clean stream, invert valid bit 40 only -> err=1 for exactly one cycle after bit 40 and 0 elsewhere; err_count=1; locked stays 1.
- Locked, invert 4 bits inside one 32-bit window -> err pulses 4 times, err_count=4, locked=0 after the 4th. Clean stream continues -> relock after 29 further valid bits with err_count still 4. The same 4 errors split 2/2 across a window boundary -> lock held.
- 200 valid bits all 0 -> locked never asserts; err_count=0. Same test with in_valid=1 only every 3rd cycle on a clean stream -> locked rises after the 29th valid bit, no state change on idle cycles.
- Locked with err_count=3, assert rst for one cycle mid-stream -> next cycle locked=0, err=0, err_count=0. Relock requires 29 new valid bits.
- CNT_W=2, WINDOW=4, ERR_LIMIT=4: inject 1 error per window for 6 windows -> err_count reads 1,2,3,3,3,3 (saturates); lock held throughout.
